// File: rtl/bf_pointer_ctrl.sv
// ----------------------------------------------------------------------------
// bf_pointer_ctrl
//
// Tracks the full/empty state of M buffers and selects the next buffer to
// serve in round-robin order, starting the search just after the buffer that
// was served last.
//
// Ports
//   i_clk       single clock, all state updates on the rising edge
//   i_rst       synchronous, active-high reset
//   i_set[M]    per-buffer fill pulse; bit i marks buffer i full
//   i_pop       consumer takes the buffer at o_ptr this cycle
//   o_full_vec  registered buffer-full flags
//   o_count     number of full buffers (0..M)
//   o_valid     at least one buffer is full
//   o_match     o_count equals K
//   o_ptr       index of the next buffer to serve (0 when nothing is full)
//   o_ovf       sticky: a fill hit a buffer that was already full
//   o_unf       sticky: a pop arrived with no full buffer
//
// All outputs derive from registered state only; there is no combinational
// path from any input to any output.
// ----------------------------------------------------------------------------
module bf_pointer_ctrl #(
    parameter int unsigned M = 4,
    parameter int unsigned K = 1,
    localparam int unsigned W = $clog2(M),
    localparam int unsigned C = $clog2(M + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [M-1:0] i_set,
    input  logic         i_pop,
    output logic [M-1:0] o_full_vec,
    output logic [C-1:0] o_count,
    output logic         o_valid,
    output logic         o_match,
    output logic [W-1:0] o_ptr,
    output logic         o_ovf,
    output logic         o_unf
);

    localparam logic [C-1:0] KVal     = C'(K);
    localparam logic [W-1:0] LastInit = W'(M - 1);

    // Registered state
    logic [M-1:0] full_q, full_d;
    logic [W-1:0] last_q, last_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    // Derived from registered state
    logic [C-1:0] count;
    logic         valid;
    logic [W-1:0] ptr;
    logic         found;

    // Next-state helpers
    logic         pop_acc;
    logic [M-1:0] pop_mask;
    logic         ovf_hit;

    // ------------------------------------------------------------------
    // Occupancy count
    // ------------------------------------------------------------------
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < M; i++) begin
            count = count + C'(full_q[i]);
        end
    end

    assign valid = |full_q;

    // ------------------------------------------------------------------
    // Round-robin pick: scan last+1, last+2, ... modulo M; the last-served
    // index is visited on the final step so it is checked last.
    // ------------------------------------------------------------------
    always_comb begin
        int unsigned  idx;
        logic [W-1:0] idx_w;
        ptr   = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int unsigned s = 1; s <= M; s++) begin
            idx   = (32'(last_q) + s) % M;
            idx_w = W'(idx);
            if (!found && full_q[idx_w]) begin
                found = 1'b1;
                ptr   = idx_w;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        pop_acc       = i_pop && valid;
        pop_mask      = '0;
        pop_mask[ptr] = pop_acc;

        // A fill on the slot being popped this cycle re-arms it without
        // counting as an overflow.
        ovf_hit = |(i_set & full_q & ~pop_mask);

        full_d = (full_q & ~pop_mask) | i_set;
        last_d = pop_acc ? ptr : last_q;
        ovf_d  = ovf_q | ovf_hit;
        unf_d  = unf_q | (i_pop && !valid);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q <= '0;
            last_q <= LastInit;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_full_vec = full_q;
    assign o_count    = count;
    assign o_valid    = valid;
    assign o_match    = (count == KVal);
    assign o_ptr      = ptr;
    assign o_ovf      = ovf_q;
    assign o_unf      = unf_q;

endmodule

// File: tb/tb_bf_pointer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bf_pointer_ctrl
//
// Drives directed scenarios followed by random traffic. A behavioural model
// predicts the outputs after every edge; predictions are queued and a
// separate monitor compares them with the DUT one cycle later.
// ----------------------------------------------------------------------------
module tb_bf_pointer_ctrl;

    localparam int unsigned M = 4;
    localparam int unsigned K = 1;
    localparam int unsigned W = $clog2(M);
    localparam int unsigned C = $clog2(M + 1);

    typedef struct packed {
        logic [M-1:0] full;
        logic [C-1:0] count;
        logic         valid;
        logic         match;
        logic [W-1:0] ptr;
        logic         ovf;
        logic         unf;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [M-1:0] i_set = '0;
    logic         i_pop = 1'b0;
    logic [M-1:0] o_full_vec;
    logic [C-1:0] o_count;
    logic         o_valid;
    logic         o_match;
    logic [W-1:0] o_ptr;
    logic         o_ovf;
    logic         o_unf;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];

    bf_pointer_ctrl #(
        .M(M),
        .K(K)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_set     (i_set),
        .i_pop     (i_pop),
        .o_full_vec(o_full_vec),
        .o_count   (o_count),
        .o_valid   (o_valid),
        .o_match   (o_match),
        .o_ptr     (o_ptr),
        .o_ovf     (o_ovf),
        .o_unf     (o_unf)
    );

    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Reference model: a set of full buffers, the last served index and
    // two sticky error bits.
    // ------------------------------------------------------------------
    bit m_full[M];
    int m_last;
    bit m_ovf;
    bit m_unf;

    function automatic int m_count();
        int n = 0;
        foreach (m_full[i]) n += m_full[i] ? 1 : 0;
        return n;
    endfunction

    // Next buffer after the last served one, wrapping; -1 if none is full.
    function automatic int m_next();
        for (int k = 1; k <= int'(M); k++) begin
            int j = (m_last + k) % int'(M);
            if (m_full[j]) return j;
        end
        return -1;
    endfunction

    function automatic void m_step(input logic [M-1:0] s, input bit p, input bit r);
        int  nxt;
        bit  taken;
        if (r) begin
            foreach (m_full[i]) m_full[i] = 1'b0;
            m_last = int'(M) - 1;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            return;
        end
        nxt   = m_next();
        taken = p && (nxt >= 0);
        if (p && nxt < 0) m_unf = 1'b1;
        for (int i = 0; i < int'(M); i++) begin
            if (s[i] && m_full[i] && !(taken && i == nxt)) m_ovf = 1'b1;
        end
        if (taken) begin
            m_full[nxt] = 1'b0;
            m_last      = nxt;
        end
        for (int i = 0; i < int'(M); i++) begin
            if (s[i]) m_full[i] = 1'b1;
        end
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        int   n   = m_count();
        int   nxt = m_next();
        for (int i = 0; i < int'(M); i++) e.full[i] = m_full[i];
        e.count = C'(n);
        e.valid = (n > 0);
        e.match = (n == int'(K));
        e.ptr   = (nxt < 0) ? '0 : W'(nxt);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    // Apply one cycle of stimulus, queue the prediction for after the edge.
    task automatic cycle(input logic [M-1:0] s, input logic p, input logic r);
        i_set = s;
        i_pop = p;
        i_rst = r;
        m_step(s, p, r);
        exp_q.push_back(m_out());
        @(posedge i_clk);
        #3;
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare outputs shortly after every edge that has a
    // pending prediction.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {o_full_vec, o_count, o_valid, o_match, o_ptr, o_ovf, o_unf};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got full=%b cnt=%0d vld=%b mat=%b ptr=%0d ovf=%b unf=%b, expected full=%b cnt=%0d vld=%b mat=%b ptr=%0d ovf=%b unf=%b",
                             $time, got.full, got.count, got.valid, got.match, got.ptr,
                             got.ovf, got.unf, e.full, e.count, e.valid, e.match, e.ptr,
                             e.ovf, e.unf);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Single buffer fill after reset
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);

        // Drain all four in order
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1111, 1'b0, 1'b0);
        repeat (4) cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);

        // Wrap-around from the top index
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1001, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);

        // Fill and pop on the same index, then a true overflow
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);

        // Underflow is sticky across later traffic
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0101, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0);

        // Reset mid-operation with fills ignored
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0110, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            logic [M-1:0] s;
            logic         p;
            logic         r;
            s = M'($urandom & $urandom);
            p = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 63) == 0);
            cycle(s, p, r);
        end

        cycle(4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
